// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver feeding a first-word fall-through byte FIFO
// Parity checking is compiled in only when PS2_RX_PARITY_CHECK_EN is defined.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   fe;
  logic                   dat_s;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic        parity_ok;
  logic        push;
  logic        frame_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          frame_err_q, overflow_q;
  logic          pop, full, wr_en, ovf_set;
  logic [7:0]    head_d;

  // Synchronisers idle high so release from reset never looks like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign fe    = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo_hit = (state_q != S_IDLE) && !fe && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (state_q == S_IDLE || fe) tmo_d = '0;
    else                         tmo_d = tmo_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (fe && !dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      S_DATA: begin
        if (fe) begin
          shift_d[bit_cnt_q] = dat_s;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fe) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    push      = fe && (state_q == S_STOP) && dat_s && parity_ok;
    frame_set = (fe && (state_q == S_STOP) && !(dat_s && parity_ok)) || tmo_hit;
  end

  assign pop     = rd_en && (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    // The byte landing this edge is the new head when nothing older remains.
    head_d    = (wr_en && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem[rd_ptr_d];
    rd_data_d = (count_d != '0) ? head_d : rd_data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      frame_err_q <= (frame_err_q && !clr_err) || frame_set;
      overflow_q  <= (overflow_q && !clr_err) || ovf_set;
    end
  end

  assign rd_data   = rd_data_q;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL be the number of received-byte entries; power of two, minimum 2.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the flip-flop stages on PS2_CLK and PS2_DAT; minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, SHALL be the CLOCK_50 cycles allowed between consecutive PS2_CLK falling edges inside a frame (1 ms).
REQ-004 CLOCK_50  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 Resetn  input  1  synchronous, active-low reset.
REQ-006 PS2_CLK  input  1  keyboard clock, asynchronous.
REQ-007 PS2_DAT  input  1  keyboard data, asynchronous.
REQ-008 rd_en  input  1  pop request for the head entry.
REQ-009 clr_err  input  1  clears the sticky error flags.
REQ-010 rd_data  output  8  head-of-FIFO byte, first-word fall-through.
REQ-011 empty  output  1  high when the FIFO holds no entries.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 frame_err  output  1  sticky flag for a bad stop bit, bad parity or timeout.
REQ-014 overflow  output  1  sticky flag for a byte dropped because the FIFO was full.

Function
REQ-015 PS2_CLK and PS2_DAT SHALL each pass through SYNC_STAGES flip-flops; a falling edge (fe) SHALL be detected from the last two stages of PS2_CLK.
REQ-016 The receive FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL sample synchronised PS2_DAT only in cycles where fe is high.
REQ-017 In IDLE, fe with data 0 SHALL go to DATA with the bit counter at 0; fe with data 1 SHALL leave the FSM in IDLE and record no error.
REQ-018 In DATA, each fe SHALL shift data into bit position 0 upward, LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-019 In PARITY, fe SHALL store the parity bit and go to STOP.
REQ-020 In STOP, fe SHALL return to IDLE and SHALL push the byte only if stop=1 and the parity check (REQ-033) passes; otherwise it SHALL set frame_err and drop the byte.
REQ-021 A valid push SHALL be written on the clock edge that ends the STOP fe cycle; empty=0 and the updated count SHALL be visible one cycle after the fe cycle.
REQ-022 In any state other than IDLE, TIMEOUT_CYCLES consecutive cycles without fe SHALL return the FSM to IDLE, discard the partial byte and set frame_err; the timeout counter SHALL reset on every fe and while in IDLE.
REQ-023 rd_data SHALL equal the oldest entry whenever empty=0; when empty=1, rd_data SHALL hold its last value.
REQ-024 rd_en with empty=0 SHALL pop one entry on that edge; rd_en with empty=1 SHALL be ignored and SHALL NOT underflow count.
REQ-025 Push with count=FIFO_DEPTH and no pop in the same cycle SHALL drop the byte, set overflow and leave the FIFO contents unchanged.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; count SHALL stay unchanged and overflow SHALL NOT be set.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 clr_err SHALL clear frame_err and overflow on the next edge; if a new error occurs in the same cycle as clr_err, the flag SHALL be set.

Reset
REQ-029 With Resetn=0 at a clock edge: FSM in IDLE, bit counter 0, timeout counter 0, pointers 0, count=0, empty=1, rd_data=8'h00, frame_err=0, overflow=0.
REQ-030 The synchroniser stages SHALL reset to 1 (idle bus level) so that no false fe is detected on the cycles after reset.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte; after release, the next start bit SHALL begin a fresh frame.

Configuration
REQ-032 Macro PS2_RX_PARITY_CHECK_EN SHALL select whether the parity bit is checked.
REQ-033 With PS2_RX_PARITY_CHECK_EN defined: the frame SHALL pass only if the 8 data bits plus the parity bit contain an odd number of ones; otherwise REQ-020 error handling applies.
REQ-034 Without PS2_RX_PARITY_CHECK_EN: the parity bit SHALL be sampled and ignored, and only the stop bit SHALL be checked.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> one cycle after the stop fe: empty=0, count=1, rd_data=0x1C, frame_err=0.
REQ-036 Frame 0x1C, parity 1 -> with macro: count=0, frame_err=1; without macro: rd_data=0x1C, frame_err=0.
REQ-037 TIMEOUT_CYCLES=5000; start bit plus 4 data bits, then clock held high -> frame_err=1 exactly 5000 cycles after the last fe; a following frame 0xF0 is received correctly.
REQ-038 FIFO_DEPTH=4; frames 0x01..0x05, no reads -> count=4, overflow=1; pops return 0x01, 0x02, 0x03, 0x04, then empty=1.
REQ-039 FIFO full; rd_en asserted in the cycle of a push of 0x55 -> count stays 4, overflow=0, 0x55 is read last.
REQ-040 Resetn pulsed low after 5 data bits, then a full frame 0x29 -> exactly one entry, 0x29, frame_err=0.
